control_fsm: RTL and testbench

- Multi-cycle microsequencer for the 16-bit datapath.
- Consumes the decoded IR fields (ir_1 opcode, ir_2 mode, funct) and the ALU status flags.
- Drives every load, tri-state and ALU strobe of the datapath, plus the memory read/write handshake.
- Sequence per instruction: fetch, decode, execute, back to fetch. Halts on the HALT opcode or on a memory timeout.

---
 rtl/control_fsm.sv | 279 +++++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle microsequencer for the 16-bit datapath.
//
// Each instruction runs fetch (F0..F2), decode (DEC), then an execute path.
// Every path returns to F0. HALT is terminal until reset.
// The machine reaches HALT on the HALT opcode or on a memory timeout.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ir_1 / ir_2 / funct   opcode, addressing mode and ALU function from the IR
//   flag_z / flag_n       ALU zero / negative flags (used by conditional branches)
//   mem_ready             memory completes the current read/write this cycle
//   mem_rd / mem_wr       memory read / write requests
//   ld*                   datapath register loads
//   Tmdr..Treg            data-bus tri-state enables (at most one high per cycle)
//   ALUon, fnSelect, mm   ALU enable, function select, immediate mode
//   pc_inc/sp_inc/sp_dec  PC and SP step strobes
//   illegal               one-cycle pulse in DEC on an undefined opcode
//   bus_err               sticky memory-timeout flag
//   halted                high in HALT
//   state                 current state, for debug
//
// Handshake: a memory request (mem_rd in F1/MR, mem_wr in SW) is held while
// the FSM waits. The transfer completes in the cycle where mem_ready is high.
// mem_ready is ignored in every other state.
//
// Outputs are decoded from the current state and the IR/flag inputs.
// The exception is ldMDR in F1/MR, which follows mem_ready.
// While rst_n is low all outputs are forced to 0. This drops any pending
// memory request at once.
module control_fsm #(
  parameter int unsigned TIMEOUT = 16,      // wait-cycle limit, 0 disables (max 256)
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ir_1,
  input  logic [1:0] ir_2,
  input  logic [2:0] funct,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ldMDR,
  output logic       ldMAR,
  output logic       ldIR,
  output logic       ldPC,
  output logic       ldSP,
  output logic       ldReg,
  output logic       ldALUreg,
  output logic       Tmdr,
  output logic       Tlabel,
  output logic       Tsp,
  output logic       Tpc,
  output logic       Treg,
  output logic       ALUon,
  output logic [2:0] fnSelect,
  output logic       mm,
  output logic       pc_inc,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [3:0] S_F0   = 4'd0;
  localparam logic [3:0] S_F1   = 4'd1;
  localparam logic [3:0] S_F2   = 4'd2;
  localparam logic [3:0] S_DEC  = 4'd3;
  localparam logic [3:0] S_EX   = 4'd4;
  localparam logic [3:0] S_WB   = 4'd5;
  localparam logic [3:0] S_MA   = 4'd6;
  localparam logic [3:0] S_MR   = 4'd7;
  localparam logic [3:0] S_LW   = 4'd8;
  localparam logic [3:0] S_SD   = 4'd9;
  localparam logic [3:0] S_SW   = 4'd10;
  localparam logic [3:0] S_P0   = 4'd11;
  localparam logic [3:0] S_P1   = 4'd12;
  localparam logic [3:0] S_PA   = 4'd13;
  localparam logic [3:0] S_BR   = 4'd14;
  localparam logic [3:0] S_HALT = 4'd15;

  localparam logic [3:0] OP_ALUR  = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0011;
  localparam logic [3:0] OP_PUSH  = 4'b0100;
  localparam logic [3:0] OP_POP   = 4'b0101;
  localparam logic [3:0] OP_BR    = 4'b0110;
  localparam logic [3:0] OP_BZ    = 4'b0111;
  localparam logic [3:0] OP_BN    = 4'b1000;

  localparam logic       TIMEOUT_EN = (TIMEOUT != 0);
  // Count value seen in the last allowed wait cycle.
  localparam logic [7:0] WAIT_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q, bus_err_d;

  logic in_wait;
  logic timeout_hit;
  logic is_halt_op;
  logic op_known;
  logic br_taken;

  assign in_wait     = (state_q == S_F1) || (state_q == S_MR) || (state_q == S_SW);
  // mem_ready in the last counted cycle completes the transfer, so the
  // timeout only fires while mem_ready is still low.
  assign timeout_hit = TIMEOUT_EN && in_wait && !mem_ready && (wait_cnt_q == WAIT_LAST);
  assign is_halt_op  = (ir_1 == HALT_OP);
  assign op_known    = (ir_1 <= OP_BN);
  assign br_taken    = (ir_1 == OP_BR) || ((ir_1 == OP_BZ) && flag_z) ||
                       ((ir_1 == OP_BN) && flag_n);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_F0:  state_d = S_F1;
      S_F1: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (mem_ready) state_d = S_F2;
      end
      S_F2:  state_d = S_DEC;
      S_DEC: begin
        // HALT_OP is a parameter, so it is checked first. This holds even
        // if it is set to an encoding that is otherwise defined.
        if (is_halt_op) begin
          state_d = S_HALT;
        end else begin
          case (ir_1)
            OP_ALUR, OP_ALUI:   state_d = S_EX;
            OP_LOAD, OP_STORE:  state_d = S_MA;
            OP_PUSH:            state_d = S_P0;
            OP_POP:             state_d = S_PA;
            OP_BR, OP_BZ, OP_BN: state_d = S_BR;
            default:            state_d = S_F0;   // undefined opcode: NOP
          endcase
        end
      end
      S_EX:  state_d = S_WB;
      S_WB:  state_d = S_F0;
      S_MA:  state_d = (ir_1 == OP_STORE) ? S_SD : S_MR;
      S_MR: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (mem_ready) state_d = S_LW;
      end
      S_LW:  state_d = S_F0;
      S_SD:  state_d = S_SW;
      S_SW: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (mem_ready) state_d = S_F0;
      end
      S_P0:   state_d = S_P1;
      S_P1:   state_d = S_SD;
      S_PA:   state_d = S_MR;
      S_BR:   state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  // Wait counter and sticky bus error
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q | timeout_hit;
    // No wait state leads straight into another wait state, so a change of
    // state into F1/MR/SW always means a fresh request.
    if (((state_d == S_F1) || (state_d == S_MR) || (state_d == S_SW)) &&
        (state_d != state_q)) begin
      wait_cnt_d = 8'd0;
    end else if (in_wait && !mem_ready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_F0;
      wait_cnt_q <= 8'd0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Output decode
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ldMDR    = 1'b0;
    ldMAR    = 1'b0;
    ldIR     = 1'b0;
    ldPC     = 1'b0;
    ldSP     = 1'b0;
    ldReg    = 1'b0;
    ldALUreg = 1'b0;
    Tmdr     = 1'b0;
    Tlabel   = 1'b0;
    Tsp      = 1'b0;
    Tpc      = 1'b0;
    Treg     = 1'b0;
    ALUon    = 1'b0;
    fnSelect = 3'b000;
    mm       = 1'b0;
    pc_inc   = 1'b0;
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    state    = state_q;
    if (rst_n) begin
      bus_err = bus_err_q;
      case (state_q)
        S_F0: begin
          Tpc   = 1'b1;
          ldMAR = 1'b1;
        end
        S_F1: begin
          mem_rd = 1'b1;
          ldMDR  = mem_ready;
        end
        S_F2: begin
          Tmdr   = 1'b1;
          ldIR   = 1'b1;
          pc_inc = 1'b1;
        end
        S_DEC: illegal = !is_halt_op && !op_known;
        S_EX: begin
          Treg     = 1'b1;
          ALUon    = 1'b1;
          fnSelect = funct;
          mm       = ir_1[0];
          ldALUreg = 1'b1;
        end
        S_WB: ldReg = 1'b1;
        S_MA: begin
          ldMAR = 1'b1;
          // Register-indirect addressing applies to LOAD only. Every other
          // mode, and every STORE, drives the label onto the bus.
          if ((ir_1 == OP_LOAD) && (ir_2 == 2'b01)) Treg   = 1'b1;
          else                                      Tlabel = 1'b1;
        end
        S_MR: begin
          mem_rd = 1'b1;
          ldMDR  = mem_ready;
        end
        S_LW: begin
          Tmdr   = 1'b1;
          ldReg  = 1'b1;
          sp_inc = (ir_1 == OP_POP);
        end
        S_SD: begin
          Treg  = 1'b1;
          ldMDR = 1'b1;
        end
        S_SW: mem_wr = 1'b1;
        S_P0: sp_dec = 1'b1;
        S_P1, S_PA: begin
          Tsp   = 1'b1;
          ldMAR = 1'b1;
        end
        S_BR: begin
          Tlabel = br_taken;
          ldPC   = br_taken;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [3:0]  HALT_OP = 4'b1111;

  // Bit positions of the packed output vector used by the reference model.
  localparam logic [31:0] S_RD    = 32'h1 << 0;
  localparam logic [31:0] S_WR    = 32'h1 << 1;
  localparam logic [31:0] S_LDMDR = 32'h1 << 2;
  localparam logic [31:0] S_LDMAR = 32'h1 << 3;
  localparam logic [31:0] S_LDIR  = 32'h1 << 4;
  localparam logic [31:0] S_LDPC  = 32'h1 << 5;
  localparam logic [31:0] S_LDREG = 32'h1 << 7;
  localparam logic [31:0] S_LDALU = 32'h1 << 8;
  localparam logic [31:0] S_TMDR  = 32'h1 << 9;
  localparam logic [31:0] S_TLAB  = 32'h1 << 10;
  localparam logic [31:0] S_TSP   = 32'h1 << 11;
  localparam logic [31:0] S_TPC   = 32'h1 << 12;
  localparam logic [31:0] S_TREG  = 32'h1 << 13;
  localparam logic [31:0] S_ALUON = 32'h1 << 14;
  localparam logic [31:0] S_MM    = 32'h1 << 15;
  localparam logic [31:0] S_PCINC = 32'h1 << 16;
  localparam logic [31:0] S_SPINC = 32'h1 << 17;
  localparam logic [31:0] S_SPDEC = 32'h1 << 18;
  localparam logic [31:0] S_ILL   = 32'h1 << 19;
  localparam logic [31:0] S_HALT  = 32'h1 << 20;
  localparam logic [31:0] S_BERR  = 32'h1 << 21;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ir_1 = 4'd0;
  logic [1:0] ir_2 = 2'd0;
  logic [2:0] funct = 3'd0;
  logic       flag_z = 1'b0;
  logic       flag_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic mem_rd, mem_wr, ldMDR, ldMAR, ldIR, ldPC, ldSP, ldReg, ldALUreg;
  logic Tmdr, Tlabel, Tsp, Tpc, Treg, ALUon, mm, pc_inc, sp_inc, sp_dec;
  logic illegal, bus_err, halted;
  logic [2:0] fnSelect;
  logic [3:0] state;

  control_fsm #(.TIMEOUT(TIMEOUT), .HALT_OP(HALT_OP)) dut (
    .clk(clk), .rst_n(rst_n), .ir_1(ir_1), .ir_2(ir_2), .funct(funct),
    .flag_z(flag_z), .flag_n(flag_n), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ldMDR(ldMDR), .ldMAR(ldMAR),
    .ldIR(ldIR), .ldPC(ldPC), .ldSP(ldSP), .ldReg(ldReg), .ldALUreg(ldALUreg),
    .Tmdr(Tmdr), .Tlabel(Tlabel), .Tsp(Tsp), .Tpc(Tpc), .Treg(Treg),
    .ALUon(ALUon), .fnSelect(fnSelect), .mm(mm), .pc_inc(pc_inc),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .illegal(illegal), .bus_err(bus_err),
    .halted(halted), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: one entry per expected cycle
  logic [3:0]  exp_st_q[$];
  logic [31:0] exp_q[$];
  int          drv_mr_q[$];   // 0/1 driven value, 2 = don't care (random)
  logic        model_berr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_sig();
    return {7'd0, fnSelect, bus_err, halted, illegal, sp_dec, sp_inc, pc_inc, mm,
            ALUon, Treg, Tpc, Tsp, Tlabel, Tmdr, ldALUreg, ldReg, ldSP, ldPC,
            ldIR, ldMAR, ldMDR, mem_wr, mem_rd};
  endfunction

  task automatic push(input logic [3:0] st, input logic [31:0] sig, input int mr);
    exp_st_q.push_back(st);
    exp_q.push_back(sig | (model_berr ? S_BERR : 32'd0));
    drv_mr_q.push_back(mr);
  endtask

  // Memory wait: 'delay' not-ready cycles, then a ready cycle. The request
  // is abandoned once it has been left unanswered for TIMEOUT cycles.
  task automatic mem_phase(input logic [3:0] st, input logic [31:0] base,
                           input logic [31:0] on_ready, input int delay, output bit to);
    to = 1'b0;
    if (TIMEOUT != 0 && delay >= int'(TIMEOUT)) begin
      for (int i = 0; i < int'(TIMEOUT); i++) push(st, base, 0);
      model_berr = 1'b1;
      push(4'd15, S_HALT, 2);
      to = 1'b1;
    end else begin
      for (int i = 0; i < delay; i++) push(st, base, 0);
      push(st, base | on_ready, 1);
    end
  endtask

  // Expected cycle list for one instruction, from the per-opcode sequences.
  task automatic build_instr(input logic [3:0] op, input logic [1:0] mode,
                             input logic [2:0] fn, input logic fz, input logic fng,
                             input int df, input int dm);
    bit to;
    bit taken;
    push(4'd0, S_TPC | S_LDMAR, 2);
    mem_phase(4'd1, S_RD, S_LDMDR, df, to);
    if (to) return;
    push(4'd2, S_TMDR | S_LDIR | S_PCINC, 2);
    if (op == HALT_OP) begin
      push(4'd3, 32'd0, 2);
      push(4'd15, S_HALT, 2);
      return;
    end
    case (op)
      4'd0, 4'd1: begin
        push(4'd3, 32'd0, 2);
        push(4'd4, S_TREG | S_ALUON | S_LDALU | ({29'd0, fn} << 22) | (op == 4'd1 ? S_MM : 32'd0), 2);
        push(4'd5, S_LDREG, 2);
      end
      4'd2: begin
        push(4'd3, 32'd0, 2);
        push(4'd6, S_LDMAR | ((mode == 2'b01) ? S_TREG : S_TLAB), 2);
        mem_phase(4'd7, S_RD, S_LDMDR, dm, to);
        if (!to) push(4'd8, S_TMDR | S_LDREG, 2);
      end
      4'd3: begin
        push(4'd3, 32'd0, 2);
        push(4'd6, S_LDMAR | S_TLAB, 2);
        push(4'd9, S_TREG | S_LDMDR, 2);
        mem_phase(4'd10, S_WR, 32'd0, dm, to);
      end
      4'd4: begin
        push(4'd3, 32'd0, 2);
        push(4'd11, S_SPDEC, 2);
        push(4'd12, S_TSP | S_LDMAR, 2);
        push(4'd9, S_TREG | S_LDMDR, 2);
        mem_phase(4'd10, S_WR, 32'd0, dm, to);
      end
      4'd5: begin
        push(4'd3, 32'd0, 2);
        push(4'd13, S_TSP | S_LDMAR, 2);
        mem_phase(4'd7, S_RD, S_LDMDR, dm, to);
        if (!to) push(4'd8, S_TMDR | S_LDREG | S_SPINC, 2);
      end
      4'd6, 4'd7, 4'd8: begin
        taken = (op == 4'd6) || (op == 4'd7 && fz) || (op == 4'd8 && fng);
        push(4'd3, 32'd0, 2);
        push(4'd14, taken ? (S_TLAB | S_LDPC) : 32'd0, 2);
      end
      default: push(4'd3, S_ILL, 2);
    endcase
  endtask

  // Consume the scoreboard one cycle at a time. Entered and left at a negedge.
  task automatic run_queue();
    int m;
    logic [3:0]  est;
    logic [31:0] esig;
    while (exp_q.size() > 0) begin
      est  = exp_st_q.pop_front();
      esig = exp_q.pop_front();
      m    = drv_mr_q.pop_front();
      mem_ready = (m == 2) ? 1'($urandom_range(0, 1)) : 1'(m);
      #1;
      check("state", {28'd0, state}, {28'd0, est});
      check("outs", get_sig(), esig);
      check("tri1hot", {31'd0, ($countones({Tmdr, Tlabel, Tsp, Tpc, Treg}) <= 1)}, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [1:0] mode,
                          input logic [2:0] fn, input logic fz, input logic fng,
                          input int df, input int dm);
    ir_1 = op; ir_2 = mode; funct = fn; flag_z = fz; flag_n = fng;
    build_instr(op, mode, fn, fz, fng, df, dm);
    run_queue();
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    model_berr = 1'b0;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_outs", get_sig(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int df, dm;

  initial begin
    // Reset
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_outs", get_sig(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequences
    do_instr(4'b0000, 2'b00, 3'b100, 1'b0, 1'b0, 0, 0);   // ALU reg
    do_instr(4'b0001, 2'b10, 3'b011, 1'b1, 1'b0, 0, 0);   // ALU imm
    do_instr(4'b0010, 2'b01, 3'b000, 1'b0, 1'b0, 0, 3);   // LOAD indirect, 3 waits
    do_instr(4'b0011, 2'b01, 3'b000, 1'b0, 1'b0, 1, 2);   // STORE ignores ir_2
    do_instr(4'b0100, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0);   // PUSH
    do_instr(4'b0101, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0);   // POP
    do_instr(4'b0111, 2'b00, 3'b000, 1'b0, 1'b1, 0, 0);   // BZ not taken
    do_instr(4'b0111, 2'b00, 3'b000, 1'b1, 1'b0, 0, 0);   // BZ taken
    do_instr(4'b1000, 2'b00, 3'b000, 1'b0, 1'b1, 0, 0);   // BN taken
    do_instr(4'b0010, 2'b00, 3'b000, 1'b0, 1'b0, 15, 15); // ready on last counted cycle

    // Random instruction stream (no HALT, no timeouts)
    for (int i = 0; i < 80; i++) begin
      df = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      dm = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      do_instr(4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), df, dm);
    end

    // Illegal opcode, then HALT held
    do_instr(4'b1010, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0);
    ir_1 = HALT_OP; ir_2 = 2'b00; funct = 3'd0;
    build_instr(HALT_OP, 2'b00, 3'd0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 19; i++) push(4'd15, S_HALT, 2);
    run_queue();
    reset_pulse();

    // Fetch timeout, then reset clears bus_err
    ir_1 = 4'b0000;
    build_instr(4'b0000, 2'b00, 3'd0, 1'b0, 1'b0, 16, 0);
    for (int i = 0; i < 4; i++) push(4'd15, S_HALT, 2);
    run_queue();
    reset_pulse();

    // Reset in the middle of a fetch wait
    push(4'd0, S_TPC | S_LDMAR, 2);
    for (int i = 0; i < 5; i++) push(4'd1, S_RD, 0);
    run_queue();
    mem_ready = 1'b0;
    #1;
    check("rd_pre", {31'd0, mem_rd}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rd_drop", {31'd0, mem_rd}, 32'd0);
    check("mid_state", {28'd0, state}, 32'd0);
    check("mid_berr", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_instr(4'b0110, 2'b00, 3'd0, 1'b0, 1'b0, 2, 0);    // BR after recovery

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
